// File: rtl/text_line_renderer.sv
// ---------------------------------------------------------------------------
// text_line_renderer
//
// Purpose:
//   Holds the calculator's display line as a small buffer of ASCII codes and
//   turns the running VGA pixel position into (ascii_code, char_x, char_y)
//   for the glyph-pixel stage that follows. The command side edits the line
//   through a valid/ready handshake. The video side is a fixed two-stage
//   pipeline that runs every cycle.
//
// Ports:
//   clk          system / pixel clock
//   rst          synchronous, active-high reset
//   cmd_valid    command present
//   cmd_op       00 push, 01 delete, 10 clear, 11 nop
//   cmd_char     ASCII code carried by a push
//   cmd_ready    high when a command can be accepted this cycle
//   overflow     one-cycle pulse when a push is dropped on a full line
//   char_count   number of characters currently held
//   pix_x/pix_y  current VGA column / row
//   pix_de       VGA display-enable
//   ascii_code   character for the current cell (0x20 when the cell is empty)
//   char_x       x offset inside the 32x32 cell
//   char_y       y offset inside the 32x32 cell
//   text_active  pixel lies inside the text line and pix_de was high
// ---------------------------------------------------------------------------
module text_line_renderer #(
   parameter int MAX_CHARS = 16,
   parameter int ORIGIN_X  = 64,
   parameter int ORIGIN_Y  = 48
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_valid,
   input  logic [1:0]                       cmd_op,
   input  logic [7:0]                       cmd_char,
   output logic                             cmd_ready,
   output logic                             overflow,
   output logic [$clog2(MAX_CHARS+1)-1:0]   char_count,
   input  logic [9:0]                       pix_x,
   input  logic [9:0]                       pix_y,
   input  logic                             pix_de,
   output logic [7:0]                       ascii_code,
   output logic [4:0]                       char_x,
   output logic [4:0]                       char_y,
   output logic                             text_active
);

   localparam int          CW       = $clog2(MAX_CHARS + 1);
   localparam int          AW       = $clog2(MAX_CHARS);
   localparam logic [7:0]  SPACE    = 8'h20;
   localparam logic [9:0]  OX       = 10'(ORIGIN_X);
   localparam logic [9:0]  OY       = 10'(ORIGIN_Y);
   localparam logic [10:0] REGION_W = 11'(32 * MAX_CHARS);

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [AW-1:0]   r_sweepPtr;
   logic [AW-1:0]   w_nextSweepPtr;
   logic [CW-1:0]   r_charCount;
   logic [CW-1:0]   w_nextCount;
   logic            r_overflow;
   logic            w_nextOverflow;
   logic            w_wrEn;
   logic [AW-1:0]   w_wrAddr;
   logic [7:0]      w_wrData;
   logic [AW-1:0]   w_delAddr;

   logic [7:0]      r_buf [MAX_CHARS];

   logic [9:0]      w_dx;
   logic [9:0]      w_dy;
   logic            w_inRegion;
   logic [9:0]      r_dx;
   logic [4:0]      r_dy;
   logic            r_inRegion;
   logic [AW-1:0]   r_col;
   logic [7:0]      r_asciiCode;
   logic [4:0]      r_charX;
   logic [4:0]      r_charY;
   logic            r_textActive;

   // The count is 1..MAX_CHARS whenever a delete is honoured, so the low AW
   // bits minus one always address the last held cell (MAX_CHARS wraps to 0).
   assign w_delAddr = r_charCount[AW-1:0] - 1'b1;

   // State, sweep pointer, count and overflow pulse. Reset restarts the
   // sweep from cell 0 even when it arrives in the middle of a sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_CLEAR;
         r_sweepPtr  <= '0;
         r_charCount <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_sweepPtr  <= w_nextSweepPtr;
         r_charCount <= w_nextCount;
         r_overflow  <= w_nextOverflow;
      end
   end

   // Next-state and command decode. The single buffer write port is shared
   // between the blanking sweep and push/delete, which never overlap because
   // commands are only taken in IDLE.
   always_comb begin
      w_nextState    = r_state;
      w_nextSweepPtr = r_sweepPtr;
      w_nextCount    = r_charCount;
      w_nextOverflow = 1'b0;
      w_wrEn         = 1'b0;
      w_wrAddr       = r_sweepPtr;
      w_wrData       = SPACE;
      cmd_ready      = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            w_wrEn         = 1'b1;
            w_nextSweepPtr = r_sweepPtr + 1'b1;
            if (r_sweepPtr == AW'(MAX_CHARS - 1)) begin
               w_nextState = ST_IDLE;
            end
         end
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (cmd_op)
                  2'b00: begin
                     if (r_charCount < CW'(MAX_CHARS)) begin
                        w_wrEn      = 1'b1;
                        w_wrAddr    = r_charCount[AW-1:0];
                        w_wrData    = cmd_char;
                        w_nextCount = r_charCount + 1'b1;
                     end else begin
                        w_nextOverflow = 1'b1;
                     end
                  end
                  2'b01: begin
                     if (r_charCount != '0) begin
                        w_wrEn      = 1'b1;
                        w_wrAddr    = w_delAddr;
                        w_nextCount = r_charCount - 1'b1;
                     end
                  end
                  2'b10: begin
                     w_nextCount    = '0;
                     w_nextSweepPtr = '0;
                     w_nextState    = ST_CLEAR;
                  end
                  default: begin
                  end
               endcase
            end
         end
         default: begin
            w_nextState = ST_CLEAR;
         end
      endcase
   end

   // Line buffer: plain RAM with no reset, blanked by the sweep instead.
   // The render read uses the value before any write on the same edge.
   always_ff @(posedge clk) begin
      if (w_wrEn && !rst) begin
         r_buf[w_wrAddr] <= w_wrData;
      end
   end

   assign w_dx       = pix_x - OX;
   assign w_dy       = pix_y - OY;
   assign w_inRegion = pix_de && (pix_x >= OX) && ({1'b0, w_dx} < REGION_W)
                       && (pix_y >= OY) && (w_dy < 10'd32);

   // Render stage 1: offsets from the line origin and the region test.
   // Inside the region the column always fits in AW bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dx       <= '0;
         r_dy       <= '0;
         r_inRegion <= 1'b0;
         r_col      <= '0;
      end else begin
         r_dx       <= w_dx;
         r_dy       <= w_dy[4:0];
         r_inRegion <= w_inRegion;
         r_col      <= w_dx[5 +: AW];
      end
   end

   // Render stage 2: buffer lookup. Cells at or beyond the count show a
   // space, so a freshly cleared line is blank before the sweep finishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_asciiCode  <= '0;
         r_charX      <= '0;
         r_charY      <= '0;
         r_textActive <= 1'b0;
      end else begin
         r_textActive <= r_inRegion;
         if (r_inRegion) begin
            r_asciiCode <= (CW'(r_col) < r_charCount) ? r_buf[r_col] : SPACE;
            r_charX     <= r_dx[4:0];
            r_charY     <= r_dy;
         end else begin
            r_asciiCode <= SPACE;
            r_charX     <= '0;
            r_charY     <= '0;
         end
      end
   end

   assign overflow    = r_overflow;
   assign char_count  = r_charCount;
   assign ascii_code  = r_asciiCode;
   assign char_x      = r_charX;
   assign char_y      = r_charY;
   assign text_active = r_textActive;

endmodule
